// File: rtl/bin_to_gray_if.sv
// Word-in / Gray-out bus for bin_to_gray.
// The producer (master) drives the binary word; the encoder (slave) returns the registered Gray code.
interface bin_to_gray_if #(
    parameter int N = 4
);
    logic [N-1:0] binary;
    logic         bin_valid;
    logic [N-1:0] gray;
    logic         gray_valid;

    modport master (
        output binary,
        output bin_valid,
        input  gray,
        input  gray_valid
    );

    modport slave (
        input  binary,
        input  bin_valid,
        output gray,
        output gray_valid
    );
endinterface

// File: rtl/bin_to_gray.sv
// Registered N-bit binary to reflected-Gray encoder, one word per clock, one cycle latency.
// The Gray register only loads on bin_valid, so an undriven word on idle cycles never reaches the output.
module bin_to_gray #(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bin_to_gray_if.slave  bus
);

    logic [N-1:0] gray_next;
    logic [N-1:0] gray_q;
    logic         valid_q;

    // Logical shift keeps the MSB unchanged and xors each lower bit with its upper neighbour; for N=1 this is identity.
    assign gray_next = bus.binary ^ (bus.binary >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.bin_valid;
            if (bus.bin_valid) begin
                gray_q <= gray_next;
            end
        end
    end

    assign bus.gray       = gray_q;
    assign bus.gray_valid = valid_q;

endmodule

// File: tb/tb_bin_to_gray.sv
// Self-checking bench for bin_to_gray at widths 1, 4, 8 and 64 driven from one shared stimulus word.
// A per-width reference model is compared every cycle; literal expectations pin the model's results.
module tb_bin_to_gray;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] stim = '0;
    logic        stim_valid = 1'b0;
    logic        cmp_enable = 1'b0;

    int checks = 0;
    int failures = 0;

    bin_to_gray_if #(.N(1))  bus1 ();
    bin_to_gray_if #(.N(4))  bus4 ();
    bin_to_gray_if #(.N(8))  bus8 ();
    bin_to_gray_if #(.N(64)) bus64 ();

    assign bus1.binary     = stim[0:0];
    assign bus1.bin_valid  = stim_valid;
    assign bus4.binary     = stim[3:0];
    assign bus4.bin_valid  = stim_valid;
    assign bus8.binary     = stim[7:0];
    assign bus8.bin_valid  = stim_valid;
    assign bus64.binary    = stim;
    assign bus64.bin_valid = stim_valid;

    bin_to_gray #(.N(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    bin_to_gray #(.N(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    bin_to_gray #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    bin_to_gray #(.N(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: truncate to the width, then Gray = b xor floor(b/2).
    function automatic logic [63:0] to_gray(input logic [63:0] b, input int n);
        logic [63:0] v;
        v = (n == 64) ? b : (b % (64'd1 << n));
        return v ^ (v / 64'd2);
    endfunction

    int          widths [4] = '{1, 4, 8, 64};
    logic [63:0] exp_gray [4];
    logic        exp_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) exp_gray[k] <= '0;
            exp_valid <= 1'b0;
        end else begin
            exp_valid <= stim_valid;
            if (stim_valid) begin
                for (int k = 0; k < 4; k++) exp_gray[k] <= to_gray(stim, widths[k]);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] b, input logic v);
        @(negedge clk);
        stim       = b;
        stim_valid = v;
    endtask

    always @(negedge clk) begin
        if (cmp_enable) begin
            checkOutput("model_gray_n1",  {63'b0, bus1.gray},  exp_gray[0]);
            checkOutput("model_gray_n4",  {60'b0, bus4.gray},  exp_gray[1]);
            checkOutput("model_gray_n8",  {56'b0, bus8.gray},  exp_gray[2]);
            checkOutput("model_gray_n64", bus64.gray,          exp_gray[3]);
            checkOutput("model_valid_n1",  {63'b0, bus1.gray_valid},  {63'b0, exp_valid});
            checkOutput("model_valid_n4",  {63'b0, bus4.gray_valid},  {63'b0, exp_valid});
            checkOutput("model_valid_n8",  {63'b0, bus8.gray_valid},  {63'b0, exp_valid});
            checkOutput("model_valid_n64", {63'b0, bus64.gray_valid}, {63'b0, exp_valid});
        end
    end

    logic [3:0]  seq4 [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [7:0]  prev8;
    logic        rv;
    logic [63:0] rb;

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_gray_n4",  {60'b0, bus4.gray}, 64'h0);
        checkOutput("reset_valid_n4", {63'b0, bus4.gray_valid}, 64'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        cmp_enable = 1'b1;

        // N=4 exhaustive, back to back
        for (int i = 0; i < 16; i++) begin
            applyStimulus(64'(i), 1'b1);
            @(posedge clk); #1;
            checkOutput("seq_n4_gray", {60'b0, bus4.gray}, {60'b0, seq4[i]});
            checkOutput("seq_n4_valid", {63'b0, bus4.gray_valid}, 64'h1);
        end

        // Hold with bin_valid low, including an undefined word
        applyStimulus(64'h5, 1'b1);
        @(posedge clk); #1;
        checkOutput("hold_load_gray", {60'b0, bus4.gray}, 64'h7);
        for (int i = 0; i < 3; i++) begin
            applyStimulus((i == 2) ? 64'hx : 64'hF, 1'b0);
            @(posedge clk); #1;
            checkOutput("hold_gray", {60'b0, bus4.gray}, 64'h7);
            checkOutput("hold_valid", {63'b0, bus4.gray_valid}, 64'h0);
        end

        // Reset asserted between edges clears outputs at once
        applyStimulus(64'hA, 1'b1);
        @(posedge clk); #1;
        checkOutput("pre_reset_gray", {60'b0, bus4.gray}, 64'hF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_gray",  {60'b0, bus4.gray}, 64'h0);
        checkOutput("async_reset_valid", {63'b0, bus4.gray_valid}, 64'h0);
        checkOutput("async_reset_gray64", bus64.gray, 64'h0);
        applyStimulus(64'h3, 1'b1);
        applyStimulus(64'h0, 1'b0);
        #2 rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("post_reset_gray",  {60'b0, bus4.gray}, 64'h0);
            checkOutput("post_reset_valid", {63'b0, bus4.gray_valid}, 64'h0);
        end

        // N=8 sweep 0..255 then wrap to 0: one bit changes per step
        for (int i = 0; i <= 256; i++) begin
            applyStimulus(64'(i % 256), 1'b1);
            @(posedge clk); #1;
            if (i > 0) checkOutput("hamming_n8", 64'($countones(prev8 ^ bus8.gray)), 64'h1);
            if (i == 255) checkOutput("wrap_n8", {56'b0, bus8.gray}, 64'h80);
            prev8 = bus8.gray;
        end

        // Width corners
        applyStimulus(64'h0, 1'b1);
        @(posedge clk); #1;
        checkOutput("n1_zero", {63'b0, bus1.gray}, 64'h0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        checkOutput("n1_one", {63'b0, bus1.gray}, 64'h1);
        checkOutput("n64_ones", bus64.gray, 64'h8000_0000_0000_0000);
        checkOutput("n4_ones", {60'b0, bus4.gray}, 64'h8);

        // Random words with random valid; idle cycles sometimes carry X
        for (int i = 0; i < 10000; i++) begin
            rv = 1'($urandom_range(0, 1));
            rb = {$urandom, $urandom};
            if (!rv && ($urandom_range(0, 3) == 0)) rb = 64'hx;
            applyStimulus(rb, rv);
        end
        applyStimulus(64'h0, 1'b0);
        @(negedge clk);
        cmp_enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
